// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x oversampled start/data/parity/stop framing, byte delivery with error flags.
// Latency: result pulses one cycle after the last stop sample; no backpressure (consumer must take rx_valid).
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over ticks 6/7/8 instead of a single tick-7 sample.
module uart_rx_deserializer #(
    parameter int BAUD_DIV_W  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  rx_en,
    input  logic [BAUD_DIV_W-1:0] baud_div,
    input  logic [3:0]            data_bits,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop_bits,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] SAMPLE_TICK = 4'd8;
`else
    localparam logic [3:0] SAMPLE_TICK = 4'd7;
`endif

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    rx_s;
    logic [BAUD_DIV_W-1:0]   tick_cnt;
    logic [BAUD_DIV_W-1:0]   div_m1;
    logic                    tick;
    logic [3:0]              sample_cnt;
    logic [2:0]              bit_cnt;
    logic [7:0]              shreg;
    logic [3:0]              nbits_in;
    logic [3:0]              nbits_q;
    logic                    par_en_q;
    logic                    par_odd_q;
    logic                    two_stop_q;
    logic                    par_err_q;
    logic                    frame_err_q;
    logic                    line_idle;
    logic                    sample_bit;
    logic                    sample_pt;
    logic                    bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_in};
        end
    end
    assign rx_s = sync[SYNC_STAGES-1];

    // >= rather than == so a baud_div shrink below the current count cannot stall the ticks
    assign div_m1 = (baud_div == '0) ? '0 : baud_div - BAUD_DIV_W'(1);
    assign tick   = (tick_cnt >= div_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + BAUD_DIV_W'(1);
        end
    end

    always_comb begin
        nbits_in = data_bits;
        if (data_bits < 4'd5) begin
            nbits_in = 4'd5;
        end else if (data_bits > 4'd8) begin
            nbits_in = 4'd8;
        end
    end

    assign sample_pt = tick && (sample_cnt == SAMPLE_TICK);
    assign bit_end   = tick && (sample_cnt == 4'd15);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote6;
    logic vote7;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote6 <= 1'b1;
            vote7 <= 1'b1;
        end else if (tick) begin
            if (sample_cnt == 4'd6) vote6 <= rx_s;
            if (sample_cnt == 4'd7) vote7 <= rx_s;
        end
    end
    assign sample_bit = (vote6 & vote7) | (vote6 & rx_s) | (vote7 & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            nbits_q      <= 4'd8;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            line_idle    <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            if (state != IDLE && tick) begin
                sample_cnt <= sample_cnt + 4'd1;
            end
            if (state != IDLE && !rx_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_s) begin
                            line_idle <= 1'b1;
                        end
                        // line_idle gates out a held-low line (break) from retriggering
                        if (rx_en && !rx_s && line_idle) begin
                            state       <= START;
                            sample_cnt  <= '0;
                            bit_cnt     <= '0;
                            shreg       <= '0;
                            nbits_q     <= nbits_in;
                            par_en_q    <= parity_en;
                            par_odd_q   <= parity_odd;
                            two_stop_q  <= stop_bits;
                            par_err_q   <= 1'b0;
                            frame_err_q <= 1'b0;
                            line_idle   <= 1'b0;
                        end
                    end
                    START: begin
                        if (sample_pt && sample_bit) begin
                            state     <= IDLE;
                            line_idle <= 1'b1;
                        end else if (bit_end) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (sample_pt) begin
                            shreg[bit_cnt] <= sample_bit;
                        end
                        if (bit_end) begin
                            if ({1'b0, bit_cnt} == nbits_q - 4'd1) begin
                                bit_cnt <= '0;
                                state   <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (sample_pt) begin
                            par_err_q <= ((^shreg) ^ sample_bit) != par_odd_q;
                        end
                        if (bit_end) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        // finishing at the last stop sample leaves half a bit to catch the next start edge
                        if (sample_pt) begin
                            if (bit_cnt[0] == two_stop_q) begin
                                state        <= IDLE;
                                rx_valid     <= 1'b1;
                                rx_data      <= shreg;
                                parity_error <= par_err_q;
                                frame_error  <= frame_err_q | ~sample_bit;
                                line_idle    <= sample_bit;
                            end else begin
                                frame_err_q <= frame_err_q | ~sample_bit;
                            end
                        end
                        if (bit_end) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: drives serial frames at 64 clk/bit, compares against a frame-level model.
module tb_uart_rx_deserializer;

    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_in;
    logic        rx_en;
    logic [15:0] baud_div;
    logic [3:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
    logic        stop_bits;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_error;
    logic        frame_error;
    logic        busy;

    uart_rx_deserializer #(.BAUD_DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_en(rx_en), .baud_div(baud_div),
        .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
        .stop_bits(stop_bits), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_error(parity_error), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_valid_cyc = 0;
    int   stray = 0;
    logic busy_mid;
    rec_t got_q[$];
    rec_t mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                mon_r.data = rx_data;
                mon_r.pe   = parity_error;
                mon_r.fe   = frame_error;
                got_q.push_back(mon_r);
                last_valid_cyc = cyc;
            end else if (parity_error || frame_error) begin
                stray++;
            end
        end
    end

    function automatic int clamp_n(input int n_raw);
        return (n_raw < 5) ? 5 : ((n_raw > 8) ? 8 : n_raw);
    endfunction

    // Frame-level expectation: masked data, parity rule over data+parity bit, any low stop bit
    function automatic rec_t model(input logic [7:0] d, input int n_raw, input logic pen,
                                   input logic podd, input logic pbit, input logic two,
                                   input logic s0, input logic s1);
        rec_t e;
        int   n = clamp_n(n_raw);
        int   ones;
        e.data = d & 8'((1 << n) - 1);
        ones   = $countones(e.data) + int'(pbit);
        e.pe   = pen && (((ones % 2) == 1) != podd);
        e.fe   = !s0 || (two && !s1);
        return e;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        rx_in = 1'b1;
        wait_clk(nbits * BIT);
    endtask

    task automatic set_cfg(input int n_raw, input logic pen, input logic podd, input logic two);
        data_bits  = 4'(n_raw);
        parity_en  = pen;
        parity_odd = podd;
        stop_bits  = two;
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic pen, input logic pbit,
                              input logic two, input logic s0, input logic s1, input bit scramble);
        logic [3:0] db;
        logic       pe_s, po_s, sb_s;
        db = data_bits; pe_s = parity_en; po_s = parity_odd; sb_s = stop_bits;
        start_cyc = cyc;
        rx_in = 1'b0;
        wait_clk(BIT / 2);
        busy_mid = busy;
        if (scramble) begin
            data_bits  = 4'($urandom);
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            stop_bits  = 1'($urandom);
        end
        wait_clk(BIT / 2);
        for (int i = 0; i < n; i++) begin
            rx_in = d[i];
            wait_clk(BIT);
        end
        if (pen) begin
            rx_in = pbit;
            wait_clk(BIT);
        end
        rx_in = s0;
        wait_clk(BIT);
        if (two) begin
            rx_in = s1;
            wait_clk(BIT);
        end
        data_bits = db; parity_en = pe_s; parity_odd = po_s; stop_bits = sb_s;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_in = 1'b1; rx_en = 1'b1; baud_div = 16'd4;
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        wait_clk(5);
        checks++;
        if ({rx_data, rx_valid, parity_error, frame_error} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 000", {rx_data, rx_valid, parity_error, frame_error});
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        wait_clk(4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_8n1;
        rec_t e, r;
        got_q.delete();
        e = model(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (busy_mid !== 1'b1) begin errors++; $display("FAIL 8n1_busy_mid: got %b want 1", busy_mid); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL 8n1_count: got %0d want 1", got_q.size());
        end else begin
            r = got_q.pop_front();
            checks++;
            if (r !== e) begin errors++; $display("FAIL 8n1_frame: got %h want %h", r, e); end
            checks++;
            if ((last_valid_cyc - start_cyc) < 600 || (last_valid_cyc - start_cyc) > 630) begin
                errors++; $display("FAIL 8n1_latency: got %0d want 600..630", last_valid_cyc - start_cyc);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_parity;
        rec_t e, r;
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            set_cfg(8, 1'b1, 1'(k), 1'b0);
            e = model(8'h3C, 8, 1'b1, 1'(k), 1'b1, 1'b0, 1'b1, 1'b1);
            send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            idle(2);
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL parity%0d_count: got %0d want 1", k, got_q.size());
            end else begin
                r = got_q.pop_front();
                checks++;
                if (r !== e) begin errors++; $display("FAIL parity%0d_frame: got %h want %h", k, r, e); end
            end
        end
        set_cfg(8, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_false_start;
        got_q.delete();
        rx_in = 1'b0;
        wait_clk(20);
        rx_in = 1'b1;
        wait_clk(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_start: got %b want 1", busy); end
        wait_clk(BIT);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy: got %b want 0", busy); end
        idle(1);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL false_start_count: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_5bit;
        rec_t e, r;
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            set_cfg(5, 1'b0, 1'b0, 1'b0);
            e = model(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'(k == 0), 1'b1);
            send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'(k == 0), 1'b1, 1'b0);
            idle(2);
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL 5bit%0d_count: got %0d want 1", k, got_q.size());
            end else begin
                r = got_q.pop_front();
                checks++;
                if (r !== e) begin errors++; $display("FAIL 5bit%0d_frame: got %h want %h", k, r, e); end
            end
        end
        set_cfg(8, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_two_stop;
        rec_t e, r;
        got_q.delete();
        set_cfg(8, 1'b0, 1'b0, 1'b1);
        e = model(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL two_stop_count: got %0d want 1", got_q.size());
        end else begin
            r = got_q.pop_front();
            checks++;
            if (r !== e) begin errors++; $display("FAIL two_stop_frame: got %h want %h", r, e); end
        end
        set_cfg(8, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        rec_t e0, e1, r;
        got_q.delete();
        e0 = model(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        e1 = model(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size());
        end else begin
            r = got_q.pop_front();
            checks++;
            if (r !== e0) begin errors++; $display("FAIL b2b_first: got %h want %h", r, e0); end
            r = got_q.pop_front();
            checks++;
            if (r !== e1) begin errors++; $display("FAIL b2b_second: got %h want %h", r, e1); end
        end
    endtask

    task automatic test_abort(input bit use_rst, input logic [7:0] prev_data);
        rec_t e, r;
        logic [7:0] d = 8'h5A;
        got_q.delete();
        rx_in = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 3; i++) begin
            rx_in = d[i];
            wait_clk(BIT);
        end
        rx_in = d[3];
        wait_clk(BIT / 2);
        if (use_rst) begin
            rst = 1'b1; wait_clk(1); rst = 1'b0;
        end else begin
            rx_en = 1'b0;
        end
        rx_in = 1'b1;
        wait_clk(4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort%0d_busy: got %b want 0", use_rst, busy); end
        wait_clk(2 * BIT);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL abort%0d_count: got %0d want 0", use_rst, got_q.size()); end
        checks++;
        if (rx_data !== (use_rst ? 8'h00 : prev_data)) begin
            errors++; $display("FAIL abort%0d_hold: got %h want %h", use_rst, rx_data, use_rst ? 8'h00 : prev_data);
        end
        rx_en = 1'b1;
        wait_clk(4);
        e = model(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL abort%0d_recover_count: got %0d want 1", use_rst, got_q.size());
        end else begin
            r = got_q.pop_front();
            checks++;
            if (r !== e) begin errors++; $display("FAIL abort%0d_recover: got %h want %h", use_rst, r, e); end
        end
    endtask

    task automatic test_break;
        rec_t e, r;
        got_q.delete();
        e = model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_in = 1'b0;
        wait_clk(20 * BIT);
        idle(2);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL break_count: got %0d want 1", got_q.size());
        end else begin
            r = got_q.pop_front();
            checks++;
            if (r !== e) begin errors++; $display("FAIL break_frame: got %h want %h", r, e); end
        end
    endtask

    task automatic test_random;
        rec_t e, r;
        int   nr;
        logic pen, podd, two, pbit, s0, s1;
        logic [7:0] d;
        for (int k = 0; k < 20; k++) begin
            got_q.delete();
            nr   = $urandom_range(3, 12);
            pen  = 1'($urandom); podd = 1'($urandom); two = 1'($urandom);
            pbit = 1'($urandom); d = 8'($urandom);
            s0   = ($urandom_range(0, 3) != 0);
            s1   = ($urandom_range(0, 3) != 0);
            set_cfg(nr, pen, podd, two);
            e = model(d, nr, pen, podd, pbit, two, s0, s1);
            send_frame(d, clamp_n(nr), pen, pbit, two, s0, s1, 1'b1);
            idle(2);
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL rand%0d_count: got %0d want 1", k, got_q.size());
            end else begin
                r = got_q.pop_front();
                checks++;
                if (r !== e) begin errors++; $display("FAIL rand%0d_frame: got %h want %h (n=%0d)", k, r, e, nr); end
            end
        end
        set_cfg(8, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_5bit();
        test_two_stop();
        test_back_to_back();
        test_abort(1'b1, 8'h00);
        test_abort(1'b0, 8'h55);
        test_break();
        test_random();
        checks++;
        if (stray != 0) begin errors++; $display("FAIL stray_error_pulses: got %0d want 0", stray); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
